lpc_i2s_tx: RTL and testbench
=============================

LPC_I2S_TX -- requirements
Module: lpc_i2s_tx

Interface
REQ-001 Parameter DEPTH, default 8, sample FIFO depth in words; power of two, at least 2.
REQ-002 Parameter BCLK_DIV, default 4, clk cycles per bclk half-period; at least 1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 v  input  1  synth sample valid strobe, one clk wide per sample; driven by decoder vout.
REQ-006 synth  input  16  signed two's-complement decoded speech sample.
REQ-007 bclk  output  1  I2S bit clock.
REQ-008 lrclk  output  1  I2S word select; 0 = left, 1 = right.
REQ-009 sdata  output  1  I2S serial data, MSB first.
REQ-010 level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-011 overflow  output  1  one-clk pulse when a push is dropped.
REQ-012 underrun  output  1  one-clk pulse when a frame starts with the FIFO empty.

Function
REQ-013 A rising clk edge with v=1 shall push synth into the FIFO unless the FIFO is full and no pop occurs in the same cycle.
REQ-014 When v=1, the FIFO is full and no pop occurs, the sample shall be dropped and overflow shall pulse for exactly 1 clk.
REQ-015 When a push and a pop occur in the same cycle, both shall complete, level shall be unchanged, and FIFO order shall be preserved.
REQ-016 A divider counter shall toggle bclk every BCLK_DIV clk cycles, giving a 50% duty cycle with period 2*BCLK_DIV.
REQ-017 A 5-bit slot counter shall advance modulo 32 in the clk cycle in which bclk goes 1 to 0; lrclk and sdata shall change only in that cycle.
REQ-018 On entry to slot 0, the FIFO head shall be popped into the frame register; if the FIFO is empty, the frame register shall load 0 and underrun shall pulse for 1 clk.
REQ-019 The mono sample shall be sent on both channels.
- Slots 1..16: sdata = frame[16-k].
- Slots 17..31: sdata = frame[32-k].
- Slot 0: sdata = frame[0] of the previous frame.
REQ-020 lrclk shall be 1 in slots 16..31 and 0 in slots 0..15, so it changes one bclk before the channel MSB (I2S standard).
REQ-021 Sample-rate mismatch shall be absorbed only by the FIFO; there shall be no other handshake to the decoder.
REQ-022 level shall be registered and shall reflect pushes and pops from the previous edge.

Reset
REQ-023 While rst=0: bclk=0, lrclk=0, sdata=0, overflow=0, underrun=0, level=0, FIFO empty, frame register=0, divider=0, slot counter=31.
REQ-024 Given the reset values, the first bclk falling edge after release shall enter slot 0 and attempt a pop.
REQ-025 Reset asserted mid-frame shall take effect immediately and discard all buffered samples.

Structure
REQ-026 Package lpc_pkg shall hold SAMPLE_W=16, I2S_SLOTS=32 and the slot-boundary constants (first left data slot 1, first right data slot 17, lrclk rise slot 16).
REQ-027 The FIFO shall be a separate sub-module, sample_fifo, providing push, pop, full, empty and level; the serializer, divider and flag logic shall stay in lpc_i2s_tx.

Verification (BCLK_DIV=2, DEPTH=8)
REQ-028 Reset release with no input -> first falling bclk at clk 4; underrun pulses; sdata stays 0 for the full 32 slots.
REQ-029 Push 16'hA5C3 before the first frame -> left slots 1..16 and right slots 17..32 both carry 1010010111000011 MSB first; lrclk rises in slot 16.
REQ-030 Push 9 samples back-to-back before any pop -> level reaches 8; overflow pulses once, on the 9th push; the 9th sample never appears on sdata.
REQ-031 FIFO full and v=1 in the same cycle as the slot-0 pop -> no overflow; level stays 8; output order is unchanged.
REQ-032 Push 16'h8000 then 16'h7FFF -> consecutive frames serialize 1 followed by fifteen 0s, then 0 followed by fifteen 1s.
REQ-033 Assert rst during slot 20 with level=5 -> all outputs return to their reset values asynchronously; after release, underrun pulses at the first slot 0.

Source files
------------

// File: rtl/lpc_pkg.sv
// lpc_pkg: shared constants and types for the LPC speech I2S transmitter.
//   SAMPLE_W        sample width (mono speech word)
//   I2S_SLOTS       bclk slots per stereo frame
//   *_SLOT          frame slot boundaries used by the serializer
//   slot_bit()      which bit of the frame register is driven in a given slot
package lpc_pkg;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned I2S_SLOTS = 32;
  localparam int unsigned SLOT_W    = $clog2(I2S_SLOTS);
  localparam int unsigned BIDX_W    = $clog2(SAMPLE_W);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [SLOT_W-1:0]   slot_t;
  typedef logic [BIDX_W-1:0]   bit_idx_t;

  localparam slot_t LEFT_FIRST_SLOT  = slot_t'(1);
  localparam slot_t RIGHT_FIRST_SLOT = slot_t'(17);
  localparam slot_t LRCLK_RISE_SLOT  = slot_t'(16);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // Slot 0 carries bit 0 of the frame still held in the register (the
  // previous frame's right-channel LSB, I2S one-bclk delay).
  function automatic bit_idx_t slot_bit(input slot_t s);
    if (s >= RIGHT_FIRST_SLOT) begin
      return bit_idx_t'(I2S_SLOTS - int'(s));
    end else if (s >= LEFT_FIRST_SLOT) begin
      return bit_idx_t'(SAMPLE_W - int'(s));
    end else begin
      return '0;
    end
  endfunction

endpackage

// File: rtl/lpc_i2s_tx_if.sv
// lpc_i2s_tx_if: decoder-sample input and I2S output bundle.
//   v, synth        sample strobe and signed sample from the decoder
//   bclk/lrclk/sdata I2S outputs
//   level           FIFO occupancy (DEPTH must match the transmitter's)
//   overflow/underrun one-clk status pulses
// master = decoder/bench side, slave = lpc_i2s_tx.
interface lpc_i2s_tx_if
  import lpc_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) ();
  logic                   v;
  sample_t                synth;
  logic                   bclk;
  logic                   lrclk;
  logic                   sdata;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic                   underrun;

  modport master (output v, synth,
                  input  bclk, lrclk, sdata, level, overflow, underrun);
  modport slave  (input  v, synth,
                  output bclk, lrclk, sdata, level, overflow, underrun);
endinterface

// File: rtl/lpc_i2s_tx_fifo.sv
// sample_fifo: DEPTH-word synchronous FIFO for speech samples.
//   push/din   write (caller must not push when full unless popping too)
//   pop/dout   read; dout shows the head word combinationally
//   full/empty occupancy flags, level registered occupancy 0..DEPTH
module sample_fifo
  import lpc_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  sample_t       din,
  output sample_t       dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  sample_t       mem_q [DEPTH];
  sample_t       mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;

endmodule

// File: rtl/lpc_i2s_tx.sv
// lpc_i2s_tx: buffers decoded speech samples and streams them as mono
// (same word on both channels) 16-bit I2S, 32 bclk slots per frame.
//   clk       sole clock
//   rst       asynchronous active-low reset
//   bus       lpc_i2s_tx_if.slave: v/synth in; bclk, lrclk, sdata, level,
//             overflow, underrun out
// Parameters: DEPTH FIFO words (power of two, >=2), BCLK_DIV clk cycles per
// bclk half-period (>=1).
module lpc_i2s_tx
  import lpc_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  lpc_i2s_tx_if.slave   bus
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  slot_t            slot_q, slot_d, slot_nxt;
  chan_e            chan_q, chan_d;
  logic             sdata_q, sdata_d;
  sample_t          frame_q, frame_d;
  logic             over_q, over_d;
  logic             under_q, under_d;

  logic             tick, fall, frame_start;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  sample_t          fifo_dout;
  logic [LVL_W-1:0] fifo_level;

  sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.synth),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign slot_nxt = slot_q + 1'b1;

  always_comb begin
    div_d   = div_q;
    bclk_d  = bclk_q;
    slot_d  = slot_q;
    chan_d  = chan_q;
    sdata_d = sdata_q;
    frame_d = frame_q;
    under_d = 1'b0;

    tick        = (div_q == DIV_W'(BCLK_DIV - 1));
    fall        = tick && bclk_q;
    frame_start = fall && (slot_nxt == '0);

    // A full FIFO still accepts the sample when the frame pop frees a word
    // in the same cycle.
    fifo_pop  = frame_start && !fifo_empty;
    fifo_push = bus.v && (!fifo_full || fifo_pop);
    over_d    = bus.v && fifo_full && !fifo_pop;

    if (tick) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    // Outputs move only on the bclk falling edge; slot 0 still reads the
    // old frame register before it is reloaded.
    if (fall) begin
      slot_d  = slot_nxt;
      chan_d  = (slot_nxt >= LRCLK_RISE_SLOT) ? CH_RIGHT : CH_LEFT;
      sdata_d = frame_q[slot_bit(slot_nxt)];
    end

    if (frame_start) begin
      if (fifo_empty) begin
        frame_d = '0;
        under_d = 1'b1;
      end else begin
        frame_d = fifo_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= '1;
      chan_q  <= CH_LEFT;
      sdata_q <= 1'b0;
      frame_q <= '0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      slot_q  <= slot_d;
      chan_q  <= chan_d;
      sdata_q <= sdata_d;
      frame_q <= frame_d;
      over_q  <= over_d;
      under_q <= under_d;
    end
  end

  assign bus.bclk     = bclk_q;
  assign bus.lrclk    = chan_q;
  assign bus.sdata    = sdata_q;
  assign bus.level    = fifo_level;
  assign bus.overflow = over_q;
  assign bus.underrun = under_q;

endmodule

// File: tb/tb_lpc_i2s_tx.sv
// tb_lpc_i2s_tx: randomized and directed stimulus for lpc_i2s_tx with a
// frame-level reference model (sample queue plus arithmetic slot timing)
// compared against every output on every clk, plus literal spot checks.
module tb_lpc_i2s_tx;
  import lpc_pkg::*;

  localparam int DEPTH = 8;
  localparam int BD    = 2;
  localparam int FR    = 2 * BD * 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lpc_i2s_tx_if #(.DEPTH(DEPTH)) bus ();

  lpc_i2s_tx #(.DEPTH(DEPTH), .BCLK_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edges since reset release and the inputs seen at each edge.
  int          pe = 0;
  logic        cap_v = 1'b0;
  logic [15:0] cap_s = '0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe <= 0;
    end else begin
      pe    <= pe + 1;
      cap_v <= bus.v;
      cap_s <= bus.synth;
    end
  end

  // Reference model: n edges since release, queue of buffered samples,
  // current and previous frame words.
  int          n = 0;
  logic [15:0] q[$];
  logic [15:0] cur = '0, prev = '0;
  logic        e_over = 1'b0, e_under = 1'b0;

  task automatic model_step();
    int slot;
    bit fall, full_b, popped;
    n++;
    e_over  = 1'b0;
    e_under = 1'b0;
    fall    = (n % (2 * BD)) == 0;
    slot    = (31 + n / (2 * BD)) % 32;
    full_b  = (q.size() == DEPTH);
    popped  = 1'b0;
    if (fall && slot == 0) begin
      prev = cur;
      if (q.size() != 0) begin
        cur = q.pop_front();
        popped = 1'b1;
      end else begin
        cur = '0;
        e_under = 1'b1;
      end
    end
    if (cap_v) begin
      if (!full_b || popped) q.push_back(cap_s);
      else e_over = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    logic eb, el, es;
    int   slot;
    if (!rst) begin
      n = 0;
      q.delete();
      cur = '0;
      prev = '0;
      e_over = 1'b0;
      e_under = 1'b0;
      eb = 1'b0; el = 1'b0; es = 1'b0;
    end else begin
      while (n < pe) model_step();
      eb = ((n / BD) % 2) == 1;
      if (n < 2 * BD) begin
        el = 1'b0;
        es = 1'b0;
      end else begin
        slot = (31 + n / (2 * BD)) % 32;
        el = (slot >= 16);
        if (slot == 0)       es = prev[0];
        else if (slot <= 16) es = cur[16 - slot];
        else                 es = cur[32 - slot];
      end
    end
    check("m_bclk",     32'(bus.bclk),     32'(eb));
    check("m_lrclk",    32'(bus.lrclk),    32'(el));
    check("m_sdata",    32'(bus.sdata),    32'(es));
    check("m_level",    32'(bus.level),    32'(q.size()));
    check("m_overflow", 32'(bus.overflow), 32'(e_over));
    check("m_underrun", 32'(bus.underrun), 32'(e_under));
  end

  int ov_cnt = 0;
  always @(negedge clk) if (bus.overflow === 1'b1) ov_cnt++;

  // Driver: after tick() returns, `last` edges have occurred since release
  // and the inputs just set apply to edge last+1.
  int   last = 0;
  logic lr_at [0:32];

  task automatic tick(input logic vv, input logic [15:0] s);
    @(posedge clk);
    #1;
    last++;
    bus.v = vv;
    bus.synth = s;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.v = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic release_rst(input logic vv, input logic [15:0] s);
    @(posedge clk);
    #1;
    rst = 1'b1;
    last = 0;
    bus.v = vv;
    bus.synth = s;
  endtask

  task automatic run_to(input int e);
    while (last < e) tick(1'b0, 16'($urandom));
  endtask

  // Sample 16 consecutive slots mid-slot, MSB first, from frame start edge fs.
  task automatic get_word(input int fs, input int first_slot, output logic [15:0] w);
    w = '0;
    for (int k = 0; k < 16; k++) begin
      run_to(fs + 2 * BD * (first_slot + k) + BD);
      w = {w[14:0], bus.sdata};
      lr_at[first_slot + k] = bus.lrclk;
    end
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] s [0:8];
    logic        any;
    int          pct;

    bus.v = 1'b0;
    bus.synth = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_bclk",  32'(bus.bclk),  32'd0);

    // Idle start: first fall at edge 4 with underrun, then silence.
    release_rst(1'b0, '0);
    run_to(3);
    check("s1_bclk_high", 32'(bus.bclk), 32'd1);
    run_to(4);
    check("s1_first_fall", 32'(bus.bclk), 32'd0);
    check("s1_underrun",   32'(bus.underrun), 32'd1);
    any = 1'b0;
    while (last < 4 + FR) begin
      tick(1'b0, '0);
      any |= bus.sdata;
    end
    check("s1_silent", 32'(any), 32'd0);

    // Single sample on both channels.
    do_reset();
    release_rst(1'b1, 16'hA5C3);
    get_word(4, 1, w);
    check("s2_left", 32'(w), 32'h0000A5C3);
    get_word(4, 17, w);
    check("s2_right", 32'(w), 32'h0000A5C3);
    check("s2_lr_slot1",  32'(lr_at[1]),  32'd0);
    check("s2_lr_slot15", 32'(lr_at[15]), 32'd0);
    check("s2_lr_slot16", 32'(lr_at[16]), 32'd1);
    check("s2_lr_slot17", 32'(lr_at[17]), 32'd1);

    // Extreme values in consecutive frames.
    do_reset();
    release_rst(1'b1, 16'h8000);
    tick(1'b1, 16'h7FFF);
    get_word(4, 1, w);
    check("s3_frame1", 32'(w), 32'h00008000);
    get_word(4 + FR, 1, w);
    check("s3_frame2", 32'(w), 32'h00007FFF);

    // Nine back-to-back pushes, then a push on the full-FIFO pop edge.
    do_reset();
    release_rst(1'b0, '0);
    run_to(4);
    ov_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      s[i] = 16'($urandom);
      tick(1'b1, s[i]);
    end
    check("s4_level_full", 32'(bus.level), 32'd8);
    run_to(14);
    check("s4_overflow", 32'(bus.overflow), 32'd1);
    check("s4_level_hold", 32'(bus.level), 32'd8);
    run_to(4 + FR - 1);
    bus.v = 1'b1;
    bus.synth = 16'($urandom);
    run_to(4 + FR);
    check("s4_pop_push_noov", 32'(bus.overflow), 32'd0);
    check("s4_pop_push_lvl",  32'(bus.level), 32'd8);
    get_word(4 + FR, 1, w);
    check("s4_order_head", 32'(w), 32'(s[0]));
    get_word(4 + 2 * FR, 1, w);
    check("s4_order_next", 32'(w), 32'(s[1]));
    run_to(4 + 10 * FR);
    check("s4_overflow_count", 32'(ov_cnt), 32'd1);

    // Reset in slot 20 with five samples buffered.
    do_reset();
    release_rst(1'b0, '0);
    run_to(4);
    for (int i = 0; i < 5; i++) tick(1'b1, 16'($urandom));
    tick(1'b0, '0);
    run_to(86);
    check("s5_pre_lrclk", 32'(bus.lrclk), 32'd1);
    check("s5_pre_level", 32'(bus.level), 32'd5);
    #3;
    rst = 1'b0;
    #1;
    check("s5_async_bclk",  32'(bus.bclk),     32'd0);
    check("s5_async_lrclk", 32'(bus.lrclk),    32'd0);
    check("s5_async_sdata", 32'(bus.sdata),    32'd0);
    check("s5_async_level", 32'(bus.level),    32'd0);
    check("s5_async_ovf",   32'(bus.overflow), 32'd0);
    check("s5_async_und",   32'(bus.underrun), 32'd0);
    repeat (2) @(posedge clk);
    release_rst(1'b0, '0);
    run_to(4);
    check("s5_underrun", 32'(bus.underrun), 32'd1);
    check("s5_empty",    32'(bus.level), 32'd0);

    // Randomized rates: slower than, faster than, then no production.
    do_reset();
    release_rst(1'b0, '0);
    for (int i = 0; i < 4000; i++) begin
      if (i < 1500)      pct = 1;
      else if (i < 2600) pct = 4;
      else               pct = 0;
      tick(($urandom_range(0, 99) < pct), 16'($urandom));
    end
    tick(1'b0, '0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
